fpnew_result_fifo: RTL

- Receiving end of the valid/ready result stream that leaves an FPU operation pipeline.
- Small circular FIFO that absorbs result, status, tag and aux words and presents them to the downstream consumer.
- in_ready_o depends only on registered occupancy, never combinationally on out_ready_i, which breaks the long ready chain running back through the pipeline stages.
- Flushed in lock-step with the pipeline that feeds it.

---
 rtl/fpnew_result_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fpnew_result_fifo.sv
// rtl/fpnew_result_fifo.sv - registered-ready result FIFO at the tail of the FPU pipeline
// Optional fall-through when empty: define FPNEW_RESULT_FIFO_BYPASS_EN.
module fpnew_result_fifo #(
    parameter int unsigned Depth = 2,
    parameter type FpType = logic,
    parameter type TagType = logic,
    parameter type AuxType = logic,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  FpType               result_i,
    input  logic [4:0]          status_i,
    input  TagType              tag_i,
    input  AuxType              aux_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output FpType               result_o,
    output logic [4:0]          status_o,
    output TagType              tag_o,
    output AuxType              aux_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CntWidth-1:0] count_o,
    output logic                busy_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

    typedef struct packed {
        FpType      result;
        logic [4:0] status;
        TagType     tag;
        AuxType     aux;
    } entry_t;

    entry_t                mem_q [Depth];
    entry_t                wr_entry;
    entry_t                head_entry;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  empty, full;
    logic                  push, pop, out_valid;
    logic                  do_write, do_read;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == FullCnt);
    assign wr_entry = '{result: result_i, status: status_i, tag: tag_i, aux: aux_i};

    // Ready is a function of registered occupancy only, cutting the ready chain.
    assign in_ready_o = ~full;
    assign push       = in_valid_i & in_ready_o;

`ifdef FPNEW_RESULT_FIFO_BYPASS_EN
    always_comb begin
        out_valid  = 1'b0;
        head_entry = mem_q[rd_ptr_q];
        if (!flush_i) begin
            out_valid = empty ? in_valid_i : 1'b1;
            if (empty) head_entry = wr_entry;
        end
    end
    assign pop      = out_valid & out_ready_i;
    // A word consumed straight through an empty FIFO never touches storage.
    assign do_write = push & ~(empty & out_ready_i);
    assign do_read  = pop & ~empty;
`else
    assign out_valid  = ~empty & ~flush_i;
    assign head_entry = mem_q[rd_ptr_q];
    assign pop        = out_valid & out_ready_i;
    assign do_write   = push;
    assign do_read    = pop;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_read)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (do_write && !do_read) begin
                count_d = count_q + CntWidth'(1);
            end else if (!do_write && do_read) begin
                count_d = count_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_write && !flush_i) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

    assign result_o    = head_entry.result;
    assign status_o    = head_entry.status;
    assign tag_o       = head_entry.tag;
    assign aux_o       = head_entry.aux;
    assign out_valid_o = out_valid;
    assign count_o     = count_q;
    assign busy_o      = ~empty;

endmodule
